// File: rtl/countdown_timer.sv
// Loadable, pausable countdown timer with a prescaled decrement, a one-cycle
// terminal-count pulse and an optional auto-reload for periodic ticks.
module countdown_timer #(
   parameter int N   = 4,
   parameter int DIV = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] load_val,
   input  logic         start,
   input  logic         stop,
   input  logic         clear,
   input  logic         auto_reload,
   output logic [N-1:0] q,
   output logic         busy,
   output logic         tc,
   output logic         done
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PLAST = PW'(DIV - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t         state, state_d;
   logic [N-1:0]   q_d;
   logic [N-1:0]   load_reg, load_d;
   logic [PW-1:0]  presc, presc_d;
   logic           tc_d;
   logic           tick;

   // Decrement that holds at zero, so q can never wrap to all-ones.
   function automatic logic [N-1:0] dec_sat(input logic [N-1:0] v);
      return (v == '0) ? v : v - N'(1);
   endfunction

   assign tick = (presc == PLAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         q        <= '0;
         load_reg <= '0;
         presc    <= '0;
         tc       <= 1'b0;
      end else begin
         state    <= state_d;
         q        <= q_d;
         load_reg <= load_d;
         presc    <= presc_d;
         tc       <= tc_d;
      end
   end

   always_comb begin
      state_d = state;
      q_d     = q;
      load_d  = load_reg;
      presc_d = presc;
      tc_d    = 1'b0;
      if (clear) begin
         state_d = IDLE;
         q_d     = '0;
         presc_d = '0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  load_d  = load_val;
                  presc_d = '0;
                  // A zero load is an immediate timeout; reload is not honoured.
                  if (load_val == '0) begin
                     q_d     = '0;
                     tc_d    = 1'b1;
                     state_d = DONE;
                  end else begin
                     q_d     = load_val;
                     state_d = RUN;
                  end
               end
            end
            RUN: begin
               // stop wins over a coincident tick: q and prescaler freeze as-is.
               if (stop) begin
                  state_d = PAUSE;
               end else if (tick) begin
                  presc_d = '0;
                  if (q > N'(1)) begin
                     q_d = dec_sat(q);
                  end else begin
                     tc_d = 1'b1;
                     if (auto_reload) begin
                        q_d = load_reg;
                     end else begin
                        q_d     = '0;
                        state_d = DONE;
                     end
                  end
               end else begin
                  presc_d = presc + PW'(1);
               end
            end
            PAUSE: begin
               if (start && !stop) state_d = RUN;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign busy = (state == RUN) || (state == PAUSE);
   assign done = (state == DONE);

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Loadable, pausable countdown timer built around a width-N down-count stage. It is the control stage that sits directly downstream of the free-running down counter. It takes a start value and counts it to zero at a prescaled rate. At expiry it produces a one-cycle terminal-count pulse and a done level, with optional auto-reload for periodic ticks. It feeds interrupt/event logic with tc and exposes the live count on q.

Parameters:
N, 4, count width in bits; load_val and q are N bits
DIV, 1, prescale divisor: one decrement every DIV clk cycles (DIV >= 1)

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  asynchronous, active-low reset
load_val  input  N  start/reload value, sampled on accepted start
start  input  1  level-sampled: start from IDLE/DONE, resume from PAUSE
stop  input  1  pause request while RUN
clear  input  1  synchronous abort to IDLE
auto_reload  input  1  sampled each expiry; 1 = reload and keep running
q  output  N  current count
busy  output  1  high in RUN and PAUSE
tc  output  1  registered one-cycle pulse on each expiry
done  output  1  high while in DONE

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, q=0, load_reg=0, prescaler=0.
  - tc=0, busy=0, done=0.
  - Deassertion is recognised on the next posedge.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered; busy and done are decoded from the registered state.
- Input priority each cycle: clear > stop > start > tick.
- clear=1 in any state: next state=IDLE, q=0, prescaler=0, tc=0.
- Prescaler:
  - Counts 0..DIV-1 only in RUN.
  - tick = (prescaler==DIV-1); the prescaler wraps to 0 on tick.
  - With DIV=1, tick is every RUN cycle.
  - Prescaler width = max(1, clog2(DIV)).
- IDLE and DONE, start=1:
  - load_reg<=load_val, q<=load_val, prescaler<=0, next state=RUN.
  - If load_val==0: q<=0, tc<=1, next state=DONE. This is a zero-length timeout, and auto_reload is ignored.
- RUN, tick with q>1: q<=q-1.
- RUN, tick with q==1 (expiry): tc<=1 for exactly one cycle.
  - auto_reload=1: q<=load_reg, stay RUN. Period = load_reg*DIV cycles, with no dead cycle.
  - auto_reload=0: q<=0, next state=DONE.
- RUN, stop=1: next state=PAUSE.
  - q and prescaler are frozen.
  - A coincident tick is discarded, so q is not decremented.
- RUN, start=1: ignored; no restart and no reload.
- PAUSE:
  - q and prescaler hold.
  - start=1 (stop=0): resume RUN with prescaler phase preserved and no reload.
  - stop and start both high: remain PAUSE.
- DONE: q holds 0, done=1, busy=0; holds until start or clear.
- tc timing: tc is 0 in every cycle other than the one after expiry.
- Width rule: q never underflows. It never decrements below 0 and never wraps to 2^N-1.
- load_val=2^N-1 is legal; maximum duration = (2^N-1)*DIV cycles.
- Reset mid-operation: immediate return to reset values. Any pending tc is lost.

Test Plan:
- Reset: N=4, DIV=1, rst=0 at t0 and during RUN with q=5 -> q=0, busy=0, done=0, tc=0 immediately, without waiting for a clk edge.
- One-shot: DIV=1, load_val=3, start pulse -> q=3,2,1,0 on successive cycles; tc high only in the cycle q becomes 0; done=1; busy falls with it.
- Prescale and reload: DIV=3, load_val=2, auto_reload=1 -> q decrements every 3 cycles; tc pulses every 6 cycles; q sequence 2,1,2,1...; no zero observed; busy stays 1.
- Pause/resume: DIV=1, load_val=10, stop raised when q=6 for 4 cycles, coincident with a tick -> q holds 6 throughout; after start, q=5,4,...; total run cycles = 10.
- Edge values: load_val=0 with start -> DONE next cycle, tc=1 once, q=0. load_val=15 with DIV=1 -> expiry after exactly 15 cycles.
- Priority: clear with start in RUN -> IDLE, q=0, no tc. start while RUN at q=4 -> ignored, q continues 3,2,...
